// File: rtl/sfp_link_supervisor.sv
// SFP / LVDS link supervisor: sequences the transmitter and the LVDS driver/receiver,
// qualifies the optical link from received frames, and retries on faults until a latched lockout.
module sfp_link_supervisor #(
  parameter int unsigned P_STARTUP_CYC = 400000,
  parameter int unsigned P_ACQ_TIMEOUT = 4000000,
  parameter int unsigned P_LOCK_FRAMES = 4,
  parameter int unsigned P_RX_WDT      = 40000,
  parameter int unsigned P_HOLDOFF     = 40000,
  parameter int unsigned P_LOS_FILT    = 64,
  parameter int unsigned P_MAX_RETRY   = 3
) (
  input  logic       i_clk,
  input  logic       i_res,
  input  logic       i_enable,
  input  logic       i_clr,
  input  logic       i_sfp_loss_sig,
  input  logic       i_sfp_tx_flt,
  input  logic       i_rx_frame_ok,
  output logic       o_sfp_tx_dis_n,
  output logic       o_drv_en,
  output logic       o_rcv_en_n,
  output logic       o_tx_allow,
  output logic       o_link_up,
  output logic       o_lockout,
  output logic [2:0] o_state,
  output logic [2:0] o_retry_cnt,
  output logic [7:0] o_fault_cnt
);

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned P_BIG = max2(max2(max2(P_STARTUP_CYC, P_ACQ_TIMEOUT),
                                            max2(P_RX_WDT, P_HOLDOFF)),
                                       max2(P_LOS_FILT, P_LOCK_FRAMES));
  localparam int TW = (P_BIG > 1) ? $clog2(P_BIG) : 1;

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_STARTUP = 3'd1,
    S_ACQUIRE = 3'd2,
    S_LINK_UP = 3'd3,
    S_HOLDOFF = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  logic          los_s1_q, los_s2_q, flt_s1_q, flt_s2_q;
  logic [TW-1:0] los_cnt_q, los_cnt_d;
  logic          los_f_q, los_f_d;
  state_t        state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d, frm_q, frm_d;
  logic [2:0]    retry_q, retry_d;
  logic [7:0]    fault_q, fault_d;
  logic          act_d;

  // LOS hysteresis: flip only after P_LOS_FILT consecutive samples disagree with the current value
  always_comb begin
    los_cnt_d = '0;
    los_f_d   = los_f_q;
    if (los_s2_q != los_f_q) begin
      if (los_cnt_q == TW'(P_LOS_FILT - 1)) los_f_d = los_s2_q;
      else                                  los_cnt_d = los_cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF:     state_d = S_STARTUP;
      S_STARTUP: if (tmr_q == TW'(P_STARTUP_CYC - 1)) state_d = S_ACQUIRE;
      S_ACQUIRE: begin
        if (flt_s2_q)                                                      state_d = S_HOLDOFF;
        else if (i_rx_frame_ok && frm_q == TW'(P_LOCK_FRAMES - 1))         state_d = S_LINK_UP;
        else if (tmr_q == TW'(P_ACQ_TIMEOUT - 1))                          state_d = S_HOLDOFF;
      end
      S_LINK_UP: begin
        if (flt_s2_q || los_f_d)                                           state_d = S_HOLDOFF;
        else if (!i_rx_frame_ok && tmr_q == TW'(P_RX_WDT - 1))             state_d = S_HOLDOFF;
      end
      S_HOLDOFF: if (tmr_q == TW'(P_HOLDOFF - 1))
                   state_d = (retry_q >= 3'(P_MAX_RETRY)) ? S_LOCKOUT : S_STARTUP;
      S_LOCKOUT: if (i_clr) state_d = S_OFF;
      default:   state_d = S_OFF;
    endcase
    if (!i_enable) state_d = S_OFF;
  end

  always_comb begin
    tmr_d   = tmr_q + 1'b1;
    frm_d   = frm_q;
    retry_d = retry_q;
    fault_d = fault_q;
    if (state_d != state_q) begin
      tmr_d = '0;
      frm_d = '0;
    end else if (i_rx_frame_ok) begin
      if (state_q == S_ACQUIRE) frm_d = frm_q + 1'b1;
      if (state_q == S_LINK_UP) tmr_d = '0;
    end
    if (state_d == S_OFF) retry_d = '0;
    else if (state_d != state_q && state_d == S_LINK_UP) retry_d = '0;
    else if (state_d != state_q && state_d == S_HOLDOFF && retry_q != 3'd7) retry_d = retry_q + 3'd1;
    // A clear landing with a HOLDOFF entry wins
    if (i_clr) fault_d = '0;
    else if (state_d != state_q && state_d == S_HOLDOFF && fault_q != 8'hFF) fault_d = fault_q + 8'd1;
  end

  assign act_d = (state_d == S_STARTUP) || (state_d == S_ACQUIRE) || (state_d == S_LINK_UP);

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      los_s1_q <= 1'b0;  los_s2_q <= 1'b0;
      flt_s1_q <= 1'b0;  flt_s2_q <= 1'b0;
      los_cnt_q <= '0;   los_f_q  <= 1'b1;
      state_q  <= S_OFF;
      tmr_q    <= '0;    frm_q    <= '0;
      retry_q  <= '0;    fault_q  <= '0;
      o_sfp_tx_dis_n <= 1'b0;
      o_drv_en       <= 1'b0;
      o_rcv_en_n     <= 1'b1;
      o_tx_allow     <= 1'b0;
      o_link_up      <= 1'b0;
      o_lockout      <= 1'b0;
    end else begin
      los_s1_q <= i_sfp_loss_sig;  los_s2_q <= los_s1_q;
      flt_s1_q <= i_sfp_tx_flt;    flt_s2_q <= flt_s1_q;
      los_cnt_q <= los_cnt_d;      los_f_q  <= los_f_d;
      state_q  <= state_d;
      tmr_q    <= tmr_d;           frm_q    <= frm_d;
      retry_q  <= retry_d;         fault_q  <= fault_d;
      o_sfp_tx_dis_n <= act_d;
      o_drv_en       <= act_d;
      o_rcv_en_n     <= ~act_d;
      o_tx_allow     <= (state_d == S_LINK_UP);
      o_link_up      <= (state_d == S_LINK_UP);
      o_lockout      <= (state_d == S_LOCKOUT);
    end
  end

  assign o_state     = state_q;
  assign o_retry_cnt = retry_q;
  assign o_fault_cnt = fault_q;

endmodule

// File: tb/tb_sfp_link_supervisor.sv
// Bench for sfp_link_supervisor: directed sequence plus random soak, every cycle
// compared against a reference model built from the link-management rules.
module tb_sfp_link_supervisor;
  localparam int STARTUP = 10, ACQ_TO = 50, LOCKF = 4, WDT = 20, HOLD = 8, LOSF = 4, MAXR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic res, en, clr, los, flt, frm;
  logic o_sfp_tx_dis_n, o_drv_en, o_rcv_en_n, o_tx_allow, o_link_up, o_lockout;
  logic [2:0] o_state, o_retry_cnt;
  logic [7:0] o_fault_cnt;
  logic [5:0] ctl;
  assign ctl = {o_sfp_tx_dis_n, o_drv_en, o_rcv_en_n, o_tx_allow, o_link_up, o_lockout};

  sfp_link_supervisor #(
    .P_STARTUP_CYC(STARTUP), .P_ACQ_TIMEOUT(ACQ_TO), .P_LOCK_FRAMES(LOCKF),
    .P_RX_WDT(WDT), .P_HOLDOFF(HOLD), .P_LOS_FILT(LOSF), .P_MAX_RETRY(MAXR)
  ) dut (
    .i_clk(clk), .i_res(res), .i_enable(en), .i_clr(clr),
    .i_sfp_loss_sig(los), .i_sfp_tx_flt(flt), .i_rx_frame_ok(frm),
    .o_sfp_tx_dis_n(o_sfp_tx_dis_n), .o_drv_en(o_drv_en), .o_rcv_en_n(o_rcv_en_n),
    .o_tx_allow(o_tx_allow), .o_link_up(o_link_up), .o_lockout(o_lockout),
    .o_state(o_state), .o_retry_cnt(o_retry_cnt), .o_fault_cnt(o_fault_cnt)
  );

  int n_assert = 0, n_fail = 0;

  // Reference model: state codes 0..5, plain integer timers, LOS history list
  int m_st, m_t, m_frm, m_retry, m_fault;
  bit m_losf, l1, l2, f1, f2;
  bit fs[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    bit s_los, s_flt, all1, all0;
    int nx;
    if (res) begin
      m_st = 0; m_t = 0; m_frm = 0; m_retry = 0; m_fault = 0;
      m_losf = 1'b1; fs.delete(); l1 = 0; l2 = 0; f1 = 0; f2 = 0;
      return;
    end
    s_los = l2; l2 = l1; l1 = los;
    s_flt = f2; f2 = f1; f1 = flt;
    fs.push_back(s_los);
    if (fs.size() > LOSF) void'(fs.pop_front());
    if (fs.size() == LOSF) begin
      all1 = 1; all0 = 1;
      foreach (fs[i]) begin all1 &= fs[i]; all0 &= !fs[i]; end
      if (all1) m_losf = 1;
      if (all0) m_losf = 0;
    end
    nx = m_st;
    case (m_st)
      0: nx = 1;
      1: if (m_t + 1 >= STARTUP) nx = 2;
      2: if (s_flt) nx = 4;
         else if (frm && m_frm + 1 >= LOCKF) nx = 3;
         else if (m_t + 1 >= ACQ_TO) nx = 4;
      3: if (s_flt || m_losf) nx = 4;
         else if (!frm && m_t + 1 >= WDT) nx = 4;
      4: if (m_t + 1 >= HOLD) nx = (m_retry >= MAXR) ? 5 : 1;
      5: if (clr) nx = 0;
      default: nx = 0;
    endcase
    if (!en) nx = 0;
    if (nx == 0) m_retry = 0;
    else if (nx != m_st && nx == 3) m_retry = 0;
    else if (nx != m_st && nx == 4) m_retry = (m_retry < 7) ? m_retry + 1 : 7;
    if (clr) m_fault = 0;
    else if (nx != m_st && nx == 4) m_fault = (m_fault < 255) ? m_fault + 1 : 255;
    if (nx != m_st) begin m_t = 0; m_frm = 0; end
    else begin
      m_t++;
      if (frm && m_st == 2) m_frm++;
      if (frm && m_st == 3) m_t = 0;
    end
    m_st = nx;
  endtask

  function automatic logic [5:0] exp_ctl(input int st);
    bit act;
    act = (st >= 1 && st <= 3);
    return {act, act, !act, st == 3, st == 3, st == 5};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("m_state", o_state, m_st);
    chk("m_ctl", ctl, exp_ctl(m_st));
    chk("m_retry", o_retry_cnt, m_retry);
    chk("m_fault", o_fault_cnt, m_fault);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frm = 0; ticks($urandom_range(0, 3));
      frm = 1; tick();
      frm = 0;
    end
  endtask

  initial begin
    res = 1; en = 1; clr = 0; los = 0; flt = 0; frm = 0;
    ticks(2);
    chk("rst_state", o_state, 3'd0);
    chk("rst_ctl", ctl, 6'b001000);
    chk("rst_cnt", {o_retry_cnt, o_fault_cnt}, 11'd0);

    // bring-up: one OFF cycle, exactly STARTUP cycles of STARTUP, then lock on the 4th frame
    res = 0;
    tick();                chk("startup_entry", o_state, 3'd1);
    ticks(STARTUP - 1);    chk("startup_last", o_state, 3'd1);
    tick();                chk("acq_entry", o_state, 3'd2);
    frames(LOCKF);
    chk("link_state", o_state, 3'd3);
    chk("link_ctl", ctl, 6'b110110);
    chk("link_retry", o_retry_cnt, 3'd0);

    // watchdog expiry
    ticks(WDT - 1);        chk("wdt_pre", o_state, 3'd3);
    tick();                chk("wdt_hold", o_state, 3'd4);
    chk("wdt_ctl", ctl, 6'b001000);
    chk("wdt_fault", o_fault_cnt, 8'd1);
    ticks(HOLD - 1);       chk("hold_last", o_state, 3'd4);
    tick();                chk("hold_restart", o_state, 3'd1);

    // two acquisition timeouts on top of the watchdog failure -> lockout
    ticks(STARTUP + ACQ_TO);  chk("to1_hold", o_state, 3'd4);
    ticks(HOLD + STARTUP + ACQ_TO); chk("to2_hold", o_state, 3'd4);
    ticks(HOLD);           chk("lockout_state", o_state, 3'd5);
    chk("lockout_retry", o_retry_cnt, 3'd3);
    chk("lockout_ctl", ctl, 6'b001001);
    ticks(5);              chk("lockout_sticky", o_state, 3'd5);
    clr = 1; tick(); clr = 0;
    chk("clr_state", o_state, 3'd0);
    chk("clr_fault", o_fault_cnt, 8'd0);

    // LOS filtering in LINK_UP
    tick(); ticks(STARTUP); frames(LOCKF);
    chk("los_link", o_state, 3'd3);
    frm = 1; tick(); frm = 0;
    los = 1; ticks(3); los = 0; ticks(6);
    chk("los_short", o_state, 3'd3);
    frm = 1; tick(); frm = 0;
    los = 1; ticks(5);     chk("los_pre", o_state, 3'd3);
    tick();                chk("los_hold", o_state, 3'd4);
    los = 0; ticks(HOLD);  chk("los_restart", o_state, 3'd1);

    // TX fault masked in STARTUP, acted on in ACQUIRE
    flt = 1; ticks(STARTUP - 1); chk("flt_masked", o_state, 3'd1);
    tick();                chk("flt_acq", o_state, 3'd2);
    for (int k = 0; k < 3 && o_state != 3'd4; k++) tick();
    chk("flt_hold", o_state, 3'd4);
    flt = 0;

    // enable drop in HOLDOFF
    en = 0; tick();
    chk("en_off_state", o_state, 3'd0);
    chk("en_off_ctl", ctl, 6'b001000);
    chk("en_off_retry", o_retry_cnt, 3'd0);
    en = 1;

    // reset in LINK_UP
    tick(); ticks(STARTUP); frames(LOCKF);
    chk("res_link", o_state, 3'd3);
    res = 1; tick(); res = 0;
    chk("res_state", o_state, 3'd0);
    chk("res_ctl", ctl, 6'b001000);
    chk("res_cnt", {o_retry_cnt, o_fault_cnt}, 11'd0);

    // random soak against the model
    for (int i = 0; i < 3000; i++) begin
      en  = ($urandom_range(0, 63) != 0);
      clr = ($urandom_range(0, 39) == 0);
      res = ($urandom_range(0, 499) == 0);
      frm = ($urandom_range(0, 2) == 0);
      flt = ($urandom_range(0, 149) == 0);
      if (los) los = ($urandom_range(0, 3) != 0);
      else     los = ($urandom_range(0, 29) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
